// File: rtl/pc_table_pkg.sv
// Shared types and default constants for the banked branch-target table.
package pc_table_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DONE_PC = 71;
  localparam int TGT_W   = 12;
  localparam int IDX_W   = 5;

endpackage

// File: rtl/pc_target_table_if.sv
// Lookup, program-load write and bank-clear signals of the branch-target table.
interface pc_target_table_if
  import pc_table_pkg::*;
#(
  parameter int D     = TGT_W,
  parameter int A     = IDX_W,
  parameter int BANKS = 4
) ();

  localparam int BW = $clog2(BANKS);

  logic          rd_en;
  logic [BW-1:0] rd_bank;
  logic [A-1:0]  rd_addr;
  logic [D-1:0]  target;
  logic          target_vld;
  logic          miss;
  logic          wr_en;
  logic [BW-1:0] wr_bank;
  logic [A-1:0]  wr_addr;
  logic [D-1:0]  wr_data;
  logic          wr_rdy;
  logic          clr_req;
  logic [BW-1:0] clr_bank;
  logic          busy;
  logic [7:0]    miss_cnt;

  modport master (
    output rd_en, rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data, clr_req, clr_bank,
    input  target, target_vld, miss, wr_rdy, busy, miss_cnt
  );

  modport slave (
    input  rd_en, rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data, clr_req, clr_bank,
    output target, target_vld, miss, wr_rdy, busy, miss_cnt
  );

endinterface

// File: rtl/pc_table_clear_fsm.sv
// Walks one bank entry per cycle invalidating it; a clear occupies exactly 2^A busy cycles.
module pc_table_clear_fsm
  import pc_table_pkg::*;
#(
  parameter int A  = IDX_W,
  parameter int BW = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr_req,
  input  logic [BW-1:0] clr_bank,
  output logic          busy,
  output logic          clr_stb,
  output logic [BW-1:0] bank,
  output logic [A-1:0]  ptr
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_CLEAR = CLEAR;

  logic [0:0] state;

  // Requests arriving while a clear is running are ignored; the walk only exits after the last entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      bank  <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            bank  <= clr_bank;
            ptr   <= '0;
          end
        end
        default: begin
          ptr <= ptr + A'(1);
          if (ptr == '1) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == ST_CLEAR);
  assign clr_stb = busy;

endmodule

// File: rtl/pc_target_table.sv
// Banked branch-target table with registered lookup, write bypass and a bank-clear engine.
// Define PC_TABLE_MISSCNT_EN to build the saturating miss counter; otherwise miss_cnt is 0.
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int             D              = TGT_W,
  parameter int             A              = IDX_W,
  parameter int             BANKS          = 4,
  parameter logic [D-1:0]   DEFAULT_TARGET = D'(DONE_PC)
) (
  input logic               Clk,
  input logic               Reset,
  pc_target_table_if.slave  bus
);

  localparam int BW = $clog2(BANKS);
  localparam int N  = 1 << A;

  logic [D-1:0]  mem   [BANKS][N];
  logic [N-1:0]  valid [BANKS];

  logic          busy;
  logic          clr_stb;
  logic [BW-1:0] clr_bank_q;
  logic [A-1:0]  clr_ptr;

  logic          wr_fire;
  logic          bypass;
  logic          rd_hit;
  logic          rd_miss;

  logic [D-1:0]  target_q;
  logic          target_vld_q;
  logic          miss_q;

  pc_table_clear_fsm #(.A(A), .BW(BW)) u_clear (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr_req  (bus.clr_req),
    .clr_bank (bus.clr_bank),
    .busy     (busy),
    .clr_stb  (clr_stb),
    .bank     (clr_bank_q),
    .ptr      (clr_ptr)
  );

  assign wr_fire = bus.wr_en && !busy;
  assign bypass  = wr_fire && (bus.wr_bank == bus.rd_bank) && (bus.wr_addr == bus.rd_addr);
  assign rd_hit  = valid[bus.rd_bank][bus.rd_addr];
  assign rd_miss = bus.rd_en && !bypass && !rd_hit;

  always_ff @(posedge Clk) begin
    if (wr_fire) mem[bus.wr_bank][bus.wr_addr] <= wr_data_w();
  end

  // Writes and the clear walk never overlap because writes are refused while busy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++) valid[b] <= '0;
    end else begin
      if (wr_fire) valid[bus.wr_bank][bus.wr_addr] <= 1'b1;
      if (clr_stb) valid[clr_bank_q][clr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      target_q     <= DEFAULT_TARGET;
      target_vld_q <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      target_vld_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (bypass) begin
          target_q <= bus.wr_data;
          miss_q   <= 1'b0;
        end else if (rd_hit) begin
          target_q <= mem[bus.rd_bank][bus.rd_addr];
          miss_q   <= 1'b0;
        end else begin
          target_q <= DEFAULT_TARGET;
          miss_q   <= 1'b1;
        end
      end
    end
  end

  function automatic logic [D-1:0] wr_data_w();
    return bus.wr_data;
  endfunction

  assign bus.target     = target_q;
  assign bus.target_vld = target_vld_q;
  assign bus.miss       = miss_q;
  assign bus.wr_rdy     = !busy;
  assign bus.busy       = busy;

`ifdef PC_TABLE_MISSCNT_EN
  logic [7:0] miss_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) miss_cnt_q <= '0;
    else if (rd_miss && (miss_cnt_q != 8'hFF)) miss_cnt_q <= miss_cnt_q + 8'd1;
  end

  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_target_table.sv
// Self-checking bench: vector table plus scoreboard for lookups, and sequences for clear and reset.
module tb_pc_target_table;
  import pc_table_pkg::*;

  localparam int D     = 12;
  localparam int A     = 5;
  localparam int BANKS = 4;
  localparam int N     = 32;
  localparam logic [D-1:0] DEF = 12'd71;

  typedef struct {
    logic       we;
    logic [1:0] wb;
    logic [4:0] wa;
    logic [11:0] wd;
    logic       re;
    logic [1:0] rb;
    logic [4:0] ra;
    logic [11:0] et;
    logic       em;
  } vec_t;

  typedef struct {
    logic [11:0] tgt;
    logic        miss;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;
  int   exp_misses = 0;
  exp_t sbq[$];
  vec_t vecs[10];

  always #5 Clk = ~Clk;

  pc_target_table_if #(.D(D), .A(A), .BANKS(BANKS)) bus ();

  pc_target_table #(.D(D), .A(A), .BANKS(BANKS), .DEFAULT_TARGET(DEF)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int expMissCnt();
`ifdef PC_TABLE_MISSCNT_EN
    return (exp_misses > 255) ? 255 : exp_misses;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input logic was_read);
    exp_t e;
    compare("target_vld", 32'(bus.target_vld), 32'(was_read));
    if (was_read) begin
      if (sbq.size() == 0) begin
        compare("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        compare("target", 32'(bus.target), 32'(e.tgt));
        compare("miss", 32'(bus.miss), 32'(e.miss));
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.wr_en   = v.we;
    bus.wr_bank = v.wb;
    bus.wr_addr = v.wa;
    bus.wr_data = v.wd;
    bus.rd_en   = v.re;
    bus.rd_bank = v.rb;
    bus.rd_addr = v.ra;
    if (v.re) begin
      sbq.push_back('{tgt: v.et, miss: v.em});
      if (v.em) exp_misses++;
    end
    @(posedge Clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checkOutput(v.re);
  endtask

  task automatic rd(input logic [1:0] b, input logic [4:0] a, input logic [11:0] et, input logic em);
    applyStimulus('{we: 1'b0, wb: 2'd0, wa: 5'd0, wd: 12'd0, re: 1'b1, rb: b, ra: a, et: et, em: em});
  endtask

  task automatic wr(input logic [1:0] b, input logic [4:0] a, input logic [11:0] d);
    applyStimulus('{we: 1'b1, wb: b, wa: a, wd: d, re: 1'b0, rb: 2'd0, ra: 5'd0, et: 12'd0, em: 1'b0});
  endtask

  task automatic checkResetState();
    compare("rst_target", 32'(bus.target), 32'(DEF));
    compare("rst_target_vld", 32'(bus.target_vld), 32'd0);
    compare("rst_miss", 32'(bus.miss), 32'd0);
    compare("rst_busy", 32'(bus.busy), 32'd0);
    compare("rst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    compare("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
  endtask

  initial begin
    int busy_cycles;

    vecs[0] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd0, 5'd3,  12'd71,   1'b1};
    vecs[1] = '{1'b1, 2'd1, 5'd0,  12'd20,   1'b0, 2'd0, 5'd0,  12'd0,    1'b0};
    vecs[2] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd1, 5'd0,  12'd20,   1'b0};
    vecs[3] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd0, 5'd0,  12'd71,   1'b1};
    vecs[4] = '{1'b1, 2'd2, 5'd5,  12'd56,   1'b1, 2'd2, 5'd5,  12'd56,   1'b0};
    vecs[5] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd2, 5'd5,  12'd56,   1'b0};
    vecs[6] = '{1'b1, 2'd3, 5'd31, 12'd4095, 1'b1, 2'd3, 5'd31, 12'd4095, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd3, 5'd30, 12'd71,   1'b1};
    vecs[8] = '{1'b1, 2'd1, 5'd0,  12'd7,    1'b1, 2'd2, 5'd5,  12'd56,   1'b0};
    vecs[9] = '{1'b0, 2'd0, 5'd0,  12'd0,    1'b1, 2'd1, 5'd0,  12'd7,    1'b0};

    Reset = 1'b1;
    bus.rd_en = 1'b0; bus.rd_bank = '0; bus.rd_addr = '0;
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0; bus.clr_bank = '0;
    repeat (2) @(posedge Clk);
    #1;
    checkResetState();
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Idle cycle: no pulse, last lookup result is held
    applyStimulus('{1'b0, 2'd0, 5'd0, 12'd0, 1'b0, 2'd0, 5'd0, 12'd0, 1'b0});
    compare("hold_target", 32'(bus.target), 32'd7);
    compare("hold_miss", 32'(bus.miss), 32'd0);
    compare("miss_cnt_table", 32'(bus.miss_cnt), 32'(expMissCnt()));

    for (int i = 0; i < N; i++) wr(2'd0, 5'(i), 12'(i + 100));
    for (int i = 0; i < N; i++) wr(2'd1, 5'(i), 12'(i + 200));
    rd(2'd0, 5'd31, 12'd131, 1'b0);

    bus.clr_req  = 1'b1;
    bus.clr_bank = 2'd0;
    @(posedge Clk);
    #1;
    bus.clr_req = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      if (busy_cycles == 3) begin
        compare("wr_rdy_in_clear", 32'(bus.wr_rdy), 32'd0);
        bus.wr_en = 1'b1; bus.wr_bank = 2'd1; bus.wr_addr = 5'd5; bus.wr_data = 12'd999;
      end
      if (busy_cycles == 10) begin
        bus.clr_req = 1'b1; bus.clr_bank = 2'd1;
      end
      @(posedge Clk);
      #1;
      bus.wr_en   = 1'b0;
      bus.clr_req = 1'b0;
    end
    compare("busy_cycles", 32'(busy_cycles), 32'd32);
    compare("wr_rdy_after_clear", 32'(bus.wr_rdy), 32'd1);

    for (int i = 0; i < N; i++) rd(2'd0, 5'(i), DEF, 1'b1);
    for (int i = 0; i < N; i++) rd(2'd1, 5'(i), 12'(i + 200), 1'b0);

    bus.clr_req  = 1'b1;
    bus.clr_bank = 2'd3;
    @(posedge Clk);
    #1;
    bus.clr_req = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    compare("busy_mid_clear", 32'(bus.busy), 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    exp_misses = 0;
    checkResetState();

    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < N; i++) rd(2'(b), 5'(i), DEF, 1'b1);
    compare("busy_after_reset", 32'(bus.busy), 32'd0);
    compare("miss_cnt_128", 32'(bus.miss_cnt), 32'(expMissCnt()));

    for (int i = 0; i < 300; i++) rd(2'(i % BANKS), 5'(i % N), DEF, 1'b1);
    compare("miss_cnt_sat", 32'(bus.miss_cnt), 32'(expMissCnt()));
    compare("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
